pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline. Sits beside the decode stage.
- Detects load-use hazards between ID and EX, flushes on taken branches/jumps resolved in EX, and freezes the pipeline while data memory is busy.
- Drives the enable, flush and bubble controls of the PC and all pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM_WAIT cycles before mem_error sets; must be ≥2.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_rs1  input  5  rs1 field of the instruction in ID.
- id_rs2  input  5  rs2 field of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- mem_req  input  1  MEM stage has a load/store outstanding.
- mem_ready  input  1  data memory completes the MEM access this cycle.
- pc_en  output  1  PC register update enable.
- if_id_en  output  1  IF/ID register load enable.
- if_id_flush  output  1  clear IF/ID to NOP.
- id_ex_en  output  1  ID/EX register load enable.
- id_ex_bubble  output  1  load NOP control into ID/EX.
- ex_mem_en  output  1  EX/MEM register load enable.
- mem_wb_bubble  output  1  load NOP control into MEM/WB.
- mem_error  output  1  sticky memory timeout flag.
- stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0.
- flush_count  output  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = RUN; wait counter, mem_error, stall_cycles and flush_count all 0.
  - Control outputs during reset: pc_en=1, if_id_en=1, id_ex_en=1, ex_mem_en=1, all flush/bubble outputs 0.
  - Reset asserted mid-operation (any state) aborts immediately to these values.
- Outputs are combinational from state and inputs; state and counters are registered.
- Default (no event): all enables 1, all flush/bubble outputs 0.
- load_use = ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Register x0 never causes a hazard.
- mem_busy = mem_req & ~mem_ready.
- FSM states RUN, MEM_WAIT.
- RUN, priority highest first:
  1. mem_busy:
     - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0, mem_wb_bubble=1.
     - Branch and load-use responses are suppressed this cycle; those stages are frozen and re-evaluated later.
     - Next state MEM_WAIT; wait counter = 1.
  2. ex_branch_taken:
     - if_id_flush=1, id_ex_bubble=1, pc_en=1 (PC takes the branch target).
     - flush_count increments.
     - Load-use is ignored, since the ID instruction is being discarded.
  3. load_use:
     - pc_en=0, if_id_en=0, id_ex_bubble=1.
     - Single-cycle stall; next cycle EX holds a bubble, so load_use clears without state.
- MEM_WAIT:
  - Same freeze outputs as RUN case 1 while mem_busy; wait counter increments, saturating at MEM_TIMEOUT.
  - mem_error sets when the wait counter reaches MEM_TIMEOUT; it stays set until reset. Pipeline stays frozen; the stall is not aborted.
  - mem_ready=1 or mem_req=0: outputs equal the RUN evaluation for that cycle (branch/load-use apply); next state RUN; wait counter clears.
- stall_cycles increments on every cycle with pc_en=0, outside reset.
- Both counters saturate at 2^CNT_W−1; no wrap.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 for 1 cycle → that cycle pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle (ex_mem_read=0) all defaults; stall_cycles=1.
- x0 / unused source: ex_rd=0, id_rs1=0, ex_mem_read=1 → no stall. Separately, id_rs2=ex_rd=7 with id_uses_rs2=0 → no stall.
- Branch beats load-use: ex_branch_taken=1 together with a load_use match → if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_count=1; stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → freeze outputs for 3 cycles, defaults on the 4th; stall_cycles=3; return to RUN.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held for 6 cycles → mem_error=1 from the 4th wait cycle; stays 1 after mem_ready until rst pulses low.
- Async reset mid-wait: assert rst=0 between clock edges during MEM_WAIT → outputs immediately default, counters 0, mem_error=0; RUN after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage RV32I pipeline (load-use, branch flush, memory freeze).
// Latency: control outputs are combinational from state and inputs; state, wait counter and perf counters update on clk.
// Backpressure: mem_req & ~mem_ready freezes PC and all pipeline registers until memory completes or drops the request.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2       - source register fields of the ID instruction, with id_uses_rs1/id_uses_rs2 qualifiers
//   ex_rd, ex_mem_read  - destination register of the EX instruction and its is-load flag
//   ex_branch_taken     - EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready  - MEM stage access outstanding / completing this cycle
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble - pipeline controls
//   mem_error           - sticky memory-timeout flag
//   stall_cycles        - saturating count of cycles with pc_en=0
//   flush_count         - saturating count of branch flushes
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]    WAIT_MAX = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0]    WAIT_ONE = WW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          err_nxt;
  logic          flush_evt;
  logic          load_use;
  logic          mem_busy;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mem_busy = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_error <= err_nxt;
      if (!pc_en && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush_evt && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    flush_evt     = 1'b0;
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    err_nxt       = mem_error;

    // Reset holds every control at its pass-through value, even while
    // inputs still signal a hazard or a busy memory.
    if (rst) begin
      if (mem_busy) begin
        // Freeze everything upstream of MEM; branch and load-use decisions
        // are deferred because the stages that produced them do not advance.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
        if (state == RUN) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_ONE;
        end else begin
          if (wait_cnt < WAIT_MAX) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
          // Flag is raised as the counter lands on the limit; the stall itself
          // continues, it is up to software to notice the error.
          if (wait_cnt >= WAIT_MAX - WAIT_ONE) begin
            err_nxt = 1'b1;
          end
        end
      end else begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
        if (ex_branch_taken) begin
          // The ID instruction is discarded, so any load-use match is moot.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_evt    = 1'b1;
        end else if (load_use) begin
          // One bubble is enough: next cycle EX holds that bubble, which is not a load.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Latency: controls sampled on the falling edge of the cycle they are driven; counters read 1 time unit after the rising edge.
// Backpressure: none; every wait is a fixed number of clock cycles.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  // Expected control vectors: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] BR  = 7'b1111110;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble;
  logic          mem_error;
  logic [CW-1:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_en        (id_ex_en),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_error       (mem_error),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, mem_error};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic req, input logic rdy);
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_branch_taken = br;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at rising edge + 1 with inputs already applied; queues the expectation,
  // compares on the falling edge, and returns at the next rising edge + 1.
  task automatic step(input string tag, input logic [6:0] ctrl, input logic err);
    sb_t e;
    sb_t got;
    e.tag = tag;
    e.exp = {ctrl, err};
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    chk(got.tag, {24'd0, obs_vec()}, {24'd0, got.exp});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int stall, input int flush);
    chk({tag, "_stall"}, 32'(stall_cycles), stall);
    chk({tag, "_flush"}, 32'(flush_count), flush);
  endtask

  initial begin
    // Reset applied with a busy memory on the inputs: controls must still be pass-through.
    rst = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("reset_ctrl", {24'd0, obs_vec()}, {24'd0, DEF, 1'b0});
    chk_cnt("reset", 0, 0);
    idle();
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    step("idle", DEF, 1'b0);

    // Load-use on rs1: one stall cycle, then clear.
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", LU, 1'b0);
    idle();
    step("lu_after", DEF, 1'b0);
    chk_cnt("lu", 1, 0);

    // x0 destination never hazards; unused rs2 never hazards; used rs2 does.
    drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("x0", DEF, 1'b0);
    drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rs2_unused", DEF, 1'b0);
    drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", LU, 1'b0);
    idle();
    step("idle2", DEF, 1'b0);
    chk_cnt("x0", 2, 0);

    // Branch wins over a simultaneous load-use.
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_lu", BR, 1'b0);
    chk_cnt("br", 2, 1);

    // Memory busy suppresses the branch; on release the branch applies.
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("br_busy", FRZ, 1'b0);
    chk_cnt("br_busy", 3, 1);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("br_release", BR, 1'b0);
    chk_cnt("br_release", 3, 2);

    // Three wait cycles, then completion.
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("mem_wait", FRZ, 1'b0);
    mem_ready = 1'b1;
    step("mem_done", DEF, 1'b0);
    chk_cnt("mem", 6, 2);

    // Wait exit by dropping mem_req while a load-use is present.
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mem_wait2", FRZ, 1'b0);
    drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("exit_lu", LU, 1'b0);
    chk_cnt("exit_lu", 8, 2);

    // Timeout: cycle 1 enters MEM_WAIT (count 1); count hits 4 at the end of
    // cycle 4, so the flag is visible from cycle 5 (4th cycle spent in MEM_WAIT).
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) step("timeout", FRZ, (i >= 5));
    mem_ready = 1'b1;
    step("timeout_done", DEF, 1'b1);
    idle();
    step("err_sticky", DEF, 1'b1);
    chk_cnt("timeout", 14, 2);

    // Saturation of both counters at 2^CW-1.
    drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("lu_sat", LU, 1'b1);
    chk_cnt("stall_sat", 15, 2);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step("br_sat", BR, 1'b1);
    chk_cnt("flush_sat", 15, 15);

    // Asynchronous reset between edges while in MEM_WAIT.
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pre_rst_wait", FRZ, 1'b1);
    step("pre_rst_wait", FRZ, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", {24'd0, obs_vec()}, {24'd0, DEF, 1'b0});
    chk_cnt("async_rst", 0, 0);
    #2 rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("post_rst", DEF, 1'b0);
    chk_cnt("post_rst", 0, 0);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("post_rst_wait", FRZ, 1'b0);
    mem_ready = 1'b1;
    step("post_rst_done", DEF, 1'b0);
    chk_cnt("post_rst_wait", 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
